// File: rtl/pipeline_if_pkg.sv
// pipeline_if_pkg -- shared constants and types for the instruction fetch stage.
//   COMMON_WIDTH     : datapath width (address and instruction)
//   NOP_INST         : instruction presented when nothing valid is buffered
//   INST_ADDR_STEP   : sequential fetch increment
//   FETCH_BUF_DEPTH  : fetch buffer depth, 2 when IF_PREFETCH_EN is defined, else 1
//   if_state_e       : fetch FSM state encoding
package pipeline_if_pkg;

    localparam int unsigned COMMON_WIDTH = 32;

    localparam logic [COMMON_WIDTH-1:0] NOP_INST       = 32'h0000_0013;
    localparam logic [COMMON_WIDTH-1:0] INST_ADDR_STEP = 32'd4;

`ifdef IF_PREFETCH_EN
    localparam int unsigned FETCH_BUF_DEPTH = 2;
`else
    localparam int unsigned FETCH_BUF_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } if_state_e;

endpackage

// File: rtl/pipeline_if_fetch_buf.sv
// if_fetch_buf -- small in-order buffer of {pc, instruction} pairs.
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_pc,
//   push_inst         : write one entry at the tail (ignored when full and not popping)
//   pop               : drop the head entry (ignored when empty)
//   flush             : discard all entries; wins over push and pop
//   head_pc, head_inst: head entry (undefined when empty)
//   full, empty       : occupancy flags
module if_fetch_buf
    import pipeline_if_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [COMMON_WIDTH-1:0] push_pc,
    input  logic [COMMON_WIDTH-1:0] push_inst,
    input  logic                    pop,
    input  logic                    flush,
    output logic [COMMON_WIDTH-1:0] head_pc,
    output logic [COMMON_WIDTH-1:0] head_inst,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [COMMON_WIDTH-1:0] pc_mem   [DEPTH];
    logic [COMMON_WIDTH-1:0] inst_mem [DEPTH];
    logic [CW-1:0]           count;
    logic [CW-1:0]           wr_idx;
    logic                    do_push;
    logic                    do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_pc   = pc_mem[0];
    assign head_inst = inst_mem[0];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        // Entry 0 is always the head, so the tail slot moves down when popping.
        wr_idx  = count - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (do_pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    pc_mem[i]   <= pc_mem[i+1];
                    inst_mem[i] <= inst_mem[i+1];
                end
            end
            if (do_push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        pc_mem[i]   <= push_pc;
                        inst_mem[i] <= push_inst;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_if.sv
// pipeline_if -- instruction fetch stage with a single outstanding memory request.
// Build option: define IF_PREFETCH_EN for a 2-entry fetch buffer (default 1 entry).
//   clk, rst               : clock, asynchronous active-low reset
//   block                  : downstream stall, 1 = instruction not accepted this cycle
//   jump_en, jump_addr     : one-cycle redirect request and its target
//   imem_req, imem_addr    : memory request and address
//   imem_gnt               : memory accepted the request this cycle
//   imem_rvalid, imem_rdata: returned instruction, one per granted request
//   inst_out, pc_out       : buffered instruction and its address
//   inst_valid             : inst_out/pc_out hold a real instruction
module pipeline_if
    import pipeline_if_pkg::*;
#(
    parameter logic [COMMON_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    block,
    input  logic                    jump_en,
    input  logic [COMMON_WIDTH-1:0] jump_addr,
    output logic                    imem_req,
    output logic [COMMON_WIDTH-1:0] imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [COMMON_WIDTH-1:0] imem_rdata,
    output logic [COMMON_WIDTH-1:0] inst_out,
    output logic [COMMON_WIDTH-1:0] pc_out,
    output logic                    inst_valid
);

    if_state_e               state, next_state;
    logic [COMMON_WIDTH-1:0] pc, pc_next;
    logic [COMMON_WIDTH-1:0] req_pc, req_pc_next;
    logic                    push;
    logic                    pop;
    logic                    granted;
    logic                    outstanding;
    logic                    full;
    logic                    empty;
    logic [COMMON_WIDTH-1:0] head_pc;
    logic [COMMON_WIDTH-1:0] head_inst;

    assign pop        = !empty && !block;
    assign inst_valid = !empty;
    assign inst_out   = empty ? NOP_INST : head_inst;
    assign pc_out     = empty ? '0 : head_pc;
    assign imem_addr  = pc;

    always_comb begin
        next_state  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        imem_req    = 1'b0;
        granted     = 1'b0;
        push        = 1'b0;
        outstanding = 1'b0;

        unique case (state)
            S_FETCH: begin
                // Occupancy is judged after this cycle's pop so a 1-entry
                // buffer still sustains one instruction per two cycles.
                imem_req = rst && (!full || pop);
                granted  = imem_req && imem_gnt;
                if (granted) begin
                    req_pc_next = pc;
                    pc_next     = pc + INST_ADDR_STEP;
                    next_state  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push       = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    next_state = S_FETCH;
                end
            end
            default: next_state = S_FETCH;
        endcase

        if (jump_en) begin
            // Only a response still in flight after this cycle must be dropped;
            // one arriving now is discarded by suppressing the push.
            outstanding = granted ||
                          ((state == S_WAIT || state == S_DROP) && !imem_rvalid);
            push        = 1'b0;
            pc_next     = jump_addr;
            next_state  = outstanding ? S_DROP : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= next_state;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    if_fetch_buf #(
        .DEPTH(FETCH_BUF_DEPTH)
    ) u_fetch_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_pc  (req_pc),
        .push_inst(imem_rdata),
        .pop      (pop),
        .flush    (jump_en),
        .head_pc  (head_pc),
        .head_inst(head_inst),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: doc/pipeline_if.md
PIPELINE_IF -- requirements
Module: pipeline_if

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
- REQ-004: block  input  1  stall from id/ex; 1 = if/id not accepting this cycle.
- REQ-005: jump_en  input  1  redirect request, one-cycle pulse.
- REQ-006: jump_addr  input  32  redirect target, word aligned.
- REQ-007: imem_req  output  1  instruction memory request valid.
- REQ-008: imem_addr  output  32  request address.
- REQ-009: imem_gnt  input  1  memory accepted request this cycle (req & gnt = handshake).
- REQ-010: imem_rvalid  input  1  read data valid; exactly one per granted request, at least one cycle after grant.
- REQ-011: imem_rdata  input  32  fetched instruction.
- REQ-012: inst_out  output  32  instruction to if/id inst_in.
- REQ-013: pc_out  output  32  address of inst_out.
- REQ-014: inst_valid  output  1  inst_out/pc_out hold a real instruction.

Function
- REQ-015: Shall keep at most one outstanding memory request; FSM states FETCH, WAIT, DROP.
- REQ-016: FETCH: imem_req=1 iff buffer occupancy < DEPTH; imem_addr=pc; on grant, latch req_pc=pc, pc<=pc+4 (wraps modulo 2^32), go WAIT.
- REQ-017: WAIT: imem_req=0; on imem_rvalid push {req_pc, imem_rdata} into the buffer, go FETCH.
- REQ-018: DROP: imem_req=0; on imem_rvalid discard data, go FETCH; nothing pushed.
- REQ-019: Output is buffer head; if buffer empty, inst_out=NOP_INST, pc_out=0, inst_valid=0.
- REQ-020: Head pops on a cycle where inst_valid=1 and block=0; push and pop in the same cycle are both honoured.
- REQ-021: jump_en=1: buffer flushed, pc<=jump_addr; next state DROP if in WAIT, or in FETCH with grant the same cycle; otherwise FETCH. jump_en in DROP keeps DROP and updates pc.
- REQ-022: jump_en takes precedence over push, pop and pc increment in the same cycle; inst_valid=0 the cycle after a jump.
- REQ-023: Latency with zero-wait memory (gnt same cycle, rvalid next cycle): first inst_valid two cycles after reset release; sustained throughput one instruction per two cycles.
- REQ-024: block held high: buffer fills to DEPTH, then imem_req deasserts; inst_out stable until popped.

Reset
- REQ-025: While rst=0: pc=RESET_PC, state FETCH, buffer empty, imem_req=0, imem_addr=RESET_PC, inst_out=NOP_INST, pc_out=0, inst_valid=0.
- REQ-026: Reset mid-operation abandons any outstanding request; instruction memory shares rst, so no stale rvalid follows.

Configuration
- REQ-027: Macro IF_PREFETCH_EN defined: buffer DEPTH=2 (fetch continues one instruction ahead during a stall); undefined: DEPTH=1.

Structure
- REQ-028: NOP_INST (32'h0000_0013), INST_ADDR_STEP (4) and the FSM state encodings shall live in the shared define.h; widths use `COMMON_WIDTH.
- REQ-029: The instruction/pc buffer shall be one sub-module, if_fetch_buf, parameterised by DEPTH with push/pop/flush/full/empty.

Verification
- REQ-030: Reset release, zero-wait memory, block=0 -> imem_addr 0,4,8...; inst_valid first high at cycle 2, pc_out 0 then 4.
- REQ-031: block=1 from cycle 5 for 6 cycles -> inst_out constant; imem_req low once occupancy=DEPTH (2 with IF_PREFETCH_EN, 1 without); no instruction lost or duplicated after release.
- REQ-032: jump_en with jump_addr=32'h100 while in WAIT -> returned rdata dropped; next imem_addr=32'h100; next valid pc_out=32'h100.
- REQ-033: jump_en coincident with grant in FETCH -> DROP entered; buffer empty; jump wins over a simultaneous pop.
- REQ-034: pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
- REQ-035: rst driven low while in WAIT with buffer holding one entry -> all outputs at REQ-025 values within the same cycle, before any clock edge.
